// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one W-bit add/AND datapath between three requesters: the AC path
//   (TAD/AND), the ISZ memory-increment path and the PC incrementer. Each
//   operation takes IDLE -> EXEC -> DONE. The grant is made in IDLE. The
//   datapath is driven combinationally during EXEC. The result is captured
//   at the end of EXEC, and a one-cycle ack pulses in DONE.
//
//   Build option: define ALU_ARB_FIXED_PRIO_EN to use fixed priority
//   PC > ISZ > AC. The default is round-robin starting after the last grant.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   ac_req/op/a/b/ci       AC-path request (op 0 = add, 1 = AND)
//   isz_req, isz_d         ISZ increment request and word
//   pc_req, pc_d           PC increment request and value
//   ac_ack/isz_ack/pc_ack  one-cycle done pulses
//   res, res_co, res_zero  registered result, carry-out, (res == 0)
//   busy                   high in EXEC and DONE
//   alu_a/b/ci/oe_add/oe_and  datapath controls, zero outside EXEC
//   alu_s, alu_co          datapath result and carry-out
module alu_arbiter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ac_req,
    input  logic         ac_op,
    input  logic [W-1:0] ac_a,
    input  logic [W-1:0] ac_b,
    input  logic         ac_ci,
    input  logic         isz_req,
    input  logic [W-1:0] isz_d,
    input  logic         pc_req,
    input  logic [W-1:0] pc_d,
    output logic         ac_ack,
    output logic         isz_ack,
    output logic         pc_ack,
    output logic [W-1:0] res,
    output logic         res_co,
    output logic         res_zero,
    output logic         busy,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_ci,
    output logic         alu_oe_add,
    output logic         alu_oe_and,
    input  logic [W-1:0] alu_s,
    input  logic         alu_co
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam logic [1:0] G_AC  = 2'd0;
    localparam logic [1:0] G_ISZ = 2'd1;
    localparam logic [1:0] G_PC  = 2'd2;

    state_t       r_state, w_next;
    logic [1:0]   r_g;
    logic [1:0]   r_lp;
    logic [1:0]   w_win;
    logic         w_any;
    logic [W-1:0] r_res;
    logic         r_co, r_zero;
    logic         r_ac_ack, r_isz_ack, r_pc_ack;
    logic [W-1:0] w_a, w_b;
    logic         w_ci, w_oe_add, w_oe_and;

    assign w_any = ac_req | isz_req | pc_req;

    // Winner selection; only consumed in IDLE when w_any is high.
    always_comb begin
        w_win = G_AC;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (pc_req)       w_win = G_PC;
        else if (isz_req) w_win = G_ISZ;
        else              w_win = G_AC;
`else
        // Search order starts with the requester after the last grant.
        case (r_lp)
            G_AC: begin
                if (isz_req)     w_win = G_ISZ;
                else if (pc_req) w_win = G_PC;
                else             w_win = G_AC;
            end
            G_ISZ: begin
                if (pc_req)      w_win = G_PC;
                else if (ac_req) w_win = G_AC;
                else             w_win = G_ISZ;
            end
            default: begin
                if (ac_req)       w_win = G_AC;
                else if (isz_req) w_win = G_ISZ;
                else              w_win = G_PC;
            end
        endcase
`endif
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath drive. Every line is zero outside EXEC, so the datapath
    // output stays tri-stated. Increments reuse the adder as d + 0 + 1.
    always_comb begin
        w_a      = '0;
        w_b      = '0;
        w_ci     = 1'b0;
        w_oe_add = 1'b0;
        w_oe_and = 1'b0;
        if (r_state == S_EXEC) begin
            case (r_g)
                G_AC: begin
                    w_a = ac_a;
                    w_b = ac_b;
                    if (ac_op) begin
                        w_oe_and = 1'b1;
                    end else begin
                        w_ci     = ac_ci;
                        w_oe_add = 1'b1;
                    end
                end
                G_ISZ: begin
                    w_a      = isz_d;
                    w_ci     = 1'b1;
                    w_oe_add = 1'b1;
                end
                G_PC: begin
                    w_a      = pc_d;
                    w_ci     = 1'b1;
                    w_oe_add = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_g       <= G_AC;
            r_lp      <= G_PC;
            r_res     <= '0;
            r_co      <= 1'b0;
            r_zero    <= 1'b1;
            r_ac_ack  <= 1'b0;
            r_isz_ack <= 1'b0;
            r_pc_ack  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ac_ack  <= 1'b0;
            r_isz_ack <= 1'b0;
            r_pc_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_g  <= w_win;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_lp <= w_win;
`endif
                    end
                end
                S_EXEC: begin
                    r_res  <= alu_s;
                    // The adder carry is meaningless when the AND output is selected.
                    r_co   <= w_oe_and ? 1'b0 : alu_co;
                    r_zero <= (alu_s == '0);
                    // Registered so the ack lines up with DONE.
                    r_ac_ack  <= (r_g == G_AC);
                    r_isz_ack <= (r_g == G_ISZ);
                    r_pc_ack  <= (r_g == G_PC);
                end
                default: ;
            endcase
        end
    end

    assign ac_ack     = r_ac_ack;
    assign isz_ack    = r_isz_ack;
    assign pc_ack     = r_pc_ack;
    assign res        = r_res;
    assign res_co     = r_co;
    assign res_zero   = r_zero;
    assign busy       = (r_state != S_IDLE);
    assign alu_a      = w_a;
    assign alu_b      = w_b;
    assign alu_ci     = w_ci;
    assign alu_oe_add = w_oe_add;
    assign alu_oe_and = w_oe_and;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. Models the add/AND datapath externally and
// scores every ack against an expected-result queue filled at issue time.
module tb_alu_arbiter;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         ac_req, ac_op, ac_ci, isz_req, pc_req;
    logic [W-1:0] ac_a, ac_b, isz_d, pc_d;
    logic         ac_ack, isz_ack, pc_ack;
    logic [W-1:0] res;
    logic         res_co, res_zero, busy;
    logic [W-1:0] alu_a, alu_b, alu_s;
    logic         alu_ci, alu_oe_add, alu_oe_and, alu_co;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .ac_req(ac_req), .ac_op(ac_op), .ac_a(ac_a), .ac_b(ac_b), .ac_ci(ac_ci),
        .isz_req(isz_req), .isz_d(isz_d), .pc_req(pc_req), .pc_d(pc_d),
        .ac_ack(ac_ack), .isz_ack(isz_ack), .pc_ack(pc_ack),
        .res(res), .res_co(res_co), .res_zero(res_zero), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
        .alu_oe_add(alu_oe_add), .alu_oe_and(alu_oe_and),
        .alu_s(alu_s), .alu_co(alu_co)
    );

    // Datapath model: the carry line always reflects a+b+ci, so the
    // arbiter must mask it for AND.
    logic [W:0] dp_sum;
    assign dp_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_ci};
    assign alu_co = dp_sum[W];
    assign alu_s  = alu_oe_add ? dp_sum[W-1:0] : (alu_oe_and ? (alu_a & alu_b) : '0);

    typedef struct packed {
        logic [2:0]   ack;   // {pc, isz, ac}
        logic [W-1:0] res;
        logic         co;
        logic         zero;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    wire [2:0] ackv = {pc_ack, isz_ack, ac_ack};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] who, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ci, input logic is_and);
        exp_t       e;
        logic [W:0] s;
        s = is_and ? {1'b0, a & b} : ({1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci});
        e.ack  = who;
        e.res  = s[W-1:0];
        e.co   = s[W];
        e.zero = (s[W-1:0] == '0);
        return e;
    endfunction

    // Scoreboard and idle-datapath monitor.
    always @(negedge clk) begin
        exp_t e;
        chk("oe_excl", {31'd0, alu_oe_add & alu_oe_and}, 32'd0);
        if (!busy) chk("idle_dp", {19'd0, alu_a, alu_ci}, 32'd0);
        if (ackv != 3'b000) begin
            chk("ack_onehot", $countones(ackv), 1);
            if (q.size() == 0) begin
                chk("unexp_ack", {29'd0, ackv}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("ack_who", {29'd0, ackv}, {29'd0, e.ack});
                chk("res", {20'd0, res}, {20'd0, e.res});
                chk("res_co", {31'd0, res_co}, {31'd0, e.co});
                chk("res_zero", {31'd0, res_zero}, {31'd0, e.zero});
            end
        end
    end

    task automatic drop_req(input int who);
        case (who)
            0: ac_req = 1'b0;
            1: isz_req = 1'b0;
            default: pc_req = 1'b0;
        endcase
    endtask

    // Waits for the ack of requester 'who', checking the EXEC datapath drive.
    task automatic wait_ack(input int who, input logic [W-1:0] ea, input logic [W-1:0] eb,
                            input logic eci, input logic eadd, input logic eand,
                            input int exp_lat, input bit drop_early);
        bit got = 0;
        for (int n = 1; n <= 12 && !got; n++) begin
            @(negedge clk);
            if (busy && ackv == 3'b000) begin
                chk("exec_a", {20'd0, alu_a}, {20'd0, ea});
                chk("exec_b", {20'd0, alu_b}, {20'd0, eb});
                chk("exec_ctl", {29'd0, alu_ci, alu_oe_add, alu_oe_and}, {29'd0, eci, eadd, eand});
                if (drop_early) drop_req(who);
            end
            if (ackv[who]) begin
                got = 1;
                if (exp_lat >= 0) chk("latency", n, exp_lat);
                drop_req(who);
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_res", {20'd0, res}, 32'd0);
        chk("rst_flags", {29'd0, res_co, res_zero, busy}, {29'd0, 3'b010});
        chk("rst_ack", {29'd0, ackv}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic issue_ac(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input bit drop_early);
        @(negedge clk);
        ac_op = op; ac_a = a; ac_b = b; ac_ci = ci; ac_req = 1'b1;
        q.push_back(mk(3'b001, a, b, op ? 1'b0 : ci, op));
        wait_ack(0, a, b, op ? 1'b0 : ci, !op, op, 2, drop_early);
    endtask

    task automatic issue_isz(input logic [W-1:0] d);
        @(negedge clk);
        isz_d = d; isz_req = 1'b1;
        q.push_back(mk(3'b010, d, '0, 1'b1, 1'b0));
        wait_ack(1, d, '0, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    endtask

    task automatic issue_pc(input logic [W-1:0] d);
        @(negedge clk);
        pc_d = d; pc_req = 1'b1;
        q.push_back(mk(3'b100, d, '0, 1'b1, 1'b0));
        wait_ack(2, d, '0, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ack;
        int t_ack[3];
        reset = 1'b1;
        ac_req = 0; ac_op = 0; ac_ci = 0; isz_req = 0; pc_req = 0;
        ac_a = '0; ac_b = '0; isz_d = '0; pc_d = '0;
        do_reset();

        // Add with carry into bit 11, then AND with ci ignored.
        issue_ac(1'b0, 12'h7FF, 12'h001, 1'b0, 1'b0);
        issue_ac(1'b1, 12'hF0F, 12'h0FF, 1'b1, 1'b0);
        issue_ac(1'b0, 12'hFFE, 12'h001, 1'b1, 1'b0);
        // ISZ wrap: skip case.
        issue_isz(12'hFFF);
        issue_isz(12'h41F);
        // The result holds while idle.
        repeat (4) @(negedge clk);
        chk("res_hold", {20'd0, res}, 32'h420);

        // Reset during EXEC aborts the operation.
        @(negedge clk);
        pc_d = 12'h123; pc_req = 1'b1;
        @(negedge clk);
        chk("abort_exec", {31'd0, busy}, 32'd1);
        reset = 1'b1; pc_req = 1'b0;
        @(negedge clk);
        chk("abort_res", {20'd0, res}, 32'd0);
        chk("abort_busy", {30'd0, busy, res_zero}, 32'd1);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        issue_pc(12'h123);

        // A request dropped during EXEC still completes, and no second grant follows.
        issue_ac(1'b0, 12'h100, 12'h200, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("no_regrant", {31'd0, busy}, 32'd0);

        // All three requests held from reset.
        reset = 1'b1;
        ac_op = 1'b0; ac_a = 12'h001; ac_b = 12'h002; ac_ci = 1'b0;
        isz_d = 12'h010; pc_d = 12'h200;
        ac_req = 1'b1; isz_req = 1'b1; pc_req = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        q.push_back(mk(3'b100, 12'h200, '0, 1'b1, 1'b0));
        q.push_back(mk(3'b010, 12'h010, '0, 1'b1, 1'b0));
        q.push_back(mk(3'b001, 12'h001, 12'h002, 1'b0, 1'b0));
`else
        q.push_back(mk(3'b001, 12'h001, 12'h002, 1'b0, 1'b0));
        q.push_back(mk(3'b010, 12'h010, '0, 1'b1, 1'b0));
        q.push_back(mk(3'b100, 12'h200, '0, 1'b1, 1'b0));
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_ack = 0;
        for (int n = 1; n <= 30 && n_ack < 3; n++) begin
            @(negedge clk);
            for (int w = 0; w < 3; w++) begin
                if (ackv[w]) begin
                    if (n_ack < 3) t_ack[n_ack] = n;
                    n_ack++;
                    drop_req(w);
                end
            end
        end
        chk("held_count", n_ack, 3);
        if (n_ack == 3) begin
            chk("held_first", t_ack[0], 2);
            chk("held_gap1", t_ack[1] - t_ack[0], 3);
            chk("held_gap2", t_ack[2] - t_ack[1], 3);
        end

        repeat (4) @(negedge clk);
        chk("q_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
